// File: rtl/led_tm1637_sequencer_pkg.sv
// Shared definitions for the TM1637 display sequencer: instruction fields, opcodes,
// driver command encodings and FSM states.
`ifndef BLOCK_ROM_INIT_ADDR_WIDTH
`define BLOCK_ROM_INIT_ADDR_WIDTH 8
`endif
`ifndef BLOCK_ROM_INIT_DATA_WIDTH
`define BLOCK_ROM_INIT_DATA_WIDTH 16
`endif

package led_tm1637_sequencer_pkg;

  localparam int unsigned OpcodeMsb  = 15;
  localparam int unsigned OpcodeLsb  = 12;
  localparam int unsigned OperandMsb = 11;
  localparam int unsigned OperandLsb = 0;

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpStart = 4'd1;
  localparam logic [3:0] OpStop  = 4'd2;
  localparam logic [3:0] OpWrite = 4'd3;
  localparam logic [3:0] OpDelay = 4'd4;
  localparam logic [3:0] OpJump  = 4'd5;
  localparam logic [3:0] OpHalt  = 4'd6;

  localparam logic [1:0] CmdStart = 2'd0;
  localparam logic [1:0] CmdStop  = 2'd1;
  localparam logic [1:0] CmdWrite = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StIssue,
    StWaitDone,
    StDelay,
    StHalted
  } state_e;

  // Only called for the three bus opcodes.
  function automatic logic [1:0] cmd_of_op(input logic [3:0] op);
    case (op)
      OpStart: return CmdStart;
      OpStop:  return CmdStop;
      default: return CmdWrite;
    endcase
  endfunction

endpackage

// File: rtl/led_tm1637_sequencer_tick.sv
// Delay prescaler: emits a one-cycle tick every TICK_DIV clocks, restartable via clear.
module led_tm1637_sequencer_tick #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntWidth = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TICK_DIV - 1);

  logic [CntWidth-1:0] count_q;

  assign tick = (count_q == CntMax);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CntWidth'(1);
    end
  end

endmodule

// File: rtl/led_tm1637_sequencer.sv
// TM1637 ROM sequencer: fetches/decodes instruction words and drives the bit-bang driver.
// Build option: define LED_TM1637_ACK_CHECK_EN to halt with error on a NACKed WRITE.
module led_tm1637_sequencer
  import led_tm1637_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic [`BLOCK_ROM_INIT_ADDR_WIDTH-1:0] rom_addr,
  input  logic [`BLOCK_ROM_INIT_DATA_WIDTH-1:0] rom_dout,
  output logic                                  cmd_valid,
  output logic [1:0]                            cmd_op,
  output logic [7:0]                            cmd_data,
  input  logic                                  cmd_ready,
  input  logic                                  cmd_done,
  input  logic                                  cmd_nack,
  output logic                                  busy,
  output logic                                  halted,
  output logic                                  error
);

  localparam int unsigned AddrWidth = `BLOCK_ROM_INIT_ADDR_WIDTH;
  localparam logic [AddrWidth-1:0] StartPc = AddrWidth'(START_ADDR);

  state_e               state_q;
  logic [AddrWidth-1:0] pc_q;
  logic [AddrWidth-1:0] pc_inc;
  logic [AddrWidth-1:0] jump_target;
  logic [15:0]          instr_q;
  logic [3:0]           opcode;
  logic [11:0]          operand;
  logic [11:0]          delay_cnt_q;
  logic                 tick;
  logic                 tick_clear;
  logic                 unused_inputs;

  assign opcode      = instr_q[OpcodeMsb:OpcodeLsb];
  assign operand     = instr_q[OperandMsb:OperandLsb];
  assign pc_inc      = pc_q + AddrWidth'(1);
  assign jump_target = AddrWidth'(operand);
  assign rom_addr    = pc_q;
  // Restart the prescaler every EXEC so a DELAY lasts exactly operand*TICK_DIV cycles.
  assign tick_clear  = (state_q == StExec);
  assign unused_inputs = ^{rom_dout, cmd_nack};

  led_tm1637_sequencer_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= StartPc;
      instr_q     <= '0;
      delay_cnt_q <= '0;
      cmd_valid   <= 1'b0;
      cmd_op      <= CmdStart;
      cmd_data    <= 8'h00;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHalted: begin
          if (start) begin
            state_q <= StFetch;
            pc_q    <= StartPc;
            busy    <= 1'b1;
            halted  <= 1'b0;
            error   <= 1'b0;
          end
        end
        StFetch: begin
          instr_q <= rom_dout[15:0];
          state_q <= StExec;
        end
        StExec: begin
          case (opcode)
            OpNop: begin
              pc_q    <= pc_inc;
              state_q <= StFetch;
            end
            OpStart, OpStop, OpWrite: begin
              cmd_valid <= 1'b1;
              cmd_op    <= cmd_of_op(opcode);
              cmd_data  <= (opcode == OpWrite) ? operand[7:0] : 8'h00;
              state_q   <= StIssue;
            end
            OpDelay: begin
              if (operand == 12'd0) begin
                pc_q    <= pc_inc;
                state_q <= StFetch;
              end else begin
                delay_cnt_q <= operand;
                state_q     <= StDelay;
              end
            end
            OpJump: begin
              pc_q    <= jump_target;
              state_q <= StFetch;
            end
            OpHalt: begin
              halted  <= 1'b1;
              busy    <= 1'b0;
              state_q <= StHalted;
            end
            default: begin
              error   <= 1'b1;
              halted  <= 1'b1;
              busy    <= 1'b0;
              state_q <= StHalted;
            end
          endcase
        end
        StIssue: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_op    <= CmdStart;
            cmd_data  <= 8'h00;
            state_q   <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (cmd_done) begin
`ifdef LED_TM1637_ACK_CHECK_EN
            if (cmd_nack && (opcode == OpWrite)) begin
              error   <= 1'b1;
              halted  <= 1'b1;
              busy    <= 1'b0;
              state_q <= StHalted;
            end else begin
              pc_q    <= pc_inc;
              state_q <= StFetch;
            end
`else
            pc_q    <= pc_inc;
            state_q <= StFetch;
`endif
          end
        end
        StDelay: begin
          if (tick) begin
            if (delay_cnt_q == 12'd1) begin
              pc_q    <= pc_inc;
              state_q <= StFetch;
            end else begin
              delay_cnt_q <= delay_cnt_q - 12'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_tm1637_sequencer.sv
// Bench for led_tm1637_sequencer: ISA-level model plus a small driver responder.
`ifndef BLOCK_ROM_INIT_ADDR_WIDTH
`define BLOCK_ROM_INIT_ADDR_WIDTH 8
`endif
`ifndef BLOCK_ROM_INIT_DATA_WIDTH
`define BLOCK_ROM_INIT_DATA_WIDTH 16
`endif

module tb_led_tm1637_sequencer;

  localparam int unsigned TickDiv   = 4;
  localparam int unsigned StartAddr = 0;
  localparam int AW       = `BLOCK_ROM_INIT_ADDR_WIDTH;
  localparam int DW       = `BLOCK_ROM_INIT_DATA_WIDTH;
  localparam int RomDepth = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic          cmd_ready, cmd_done, cmd_nack;
  logic          busy, halted, error;

  logic [15:0] rom [RomDepth];
  assign rom_dout = DW'(rom[rom_addr]);

  always #5 clk = ~clk;

  led_tm1637_sequencer #(
    .TICK_DIV  (TickDiv),
    .START_ADDR(StartAddr)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .cmd_done (cmd_done),
    .cmd_nack (cmd_nack),
    .busy     (busy),
    .halted   (halted),
    .error    (error)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver responder configuration
  int drv_w = 0;
  int drv_d = 1;
  bit drv_nack = 0;

  // Model results
  logic [9:0] exp_cmds[$];
  int         exp_trace[$];
  int         exp_cyc;
  bit         exp_err, exp_halt;

  // Observations
  logic [9:0] obs_cmds[$];
  int         obs_trace[$];
  int         last_addr;
  bit         mon_en = 0;
  int         meas;

  // Instruction-level interpreter: per-instruction cycle cost from the documented timing.
  task automatic run_model(input int limit_cyc);
    int pc, op, opd, nxt;
    bit done;
    exp_cmds.delete();
    exp_trace.delete();
    exp_cyc  = 0;
    exp_err  = 0;
    exp_halt = 0;
    pc = StartAddr;
    exp_trace.push_back(pc);
    done = 0;
    while (!done && exp_cyc < limit_cyc) begin
      op  = int'(rom[pc] >> 12);
      opd = int'(rom[pc] & 16'h0FFF);
      nxt = (pc + 1) % RomDepth;
      case (op)
        0: exp_cyc += 2;
        1, 2, 3: begin
          exp_cmds.push_back({(op == 1) ? 2'd0 : (op == 2) ? 2'd1 : 2'd2,
                              (op == 3) ? opd[7:0] : 8'h00});
          exp_cyc += 3 + drv_w + drv_d;
`ifdef LED_TM1637_ACK_CHECK_EN
          if (op == 3 && drv_nack) begin
            exp_err  = 1;
            exp_halt = 1;
            done     = 1;
          end
`endif
        end
        4: exp_cyc += 2 + opd * TickDiv;
        5: begin
          exp_cyc += 2;
          nxt = opd % RomDepth;
        end
        6: begin
          exp_cyc += 2;
          exp_halt = 1;
          done = 1;
        end
        default: begin
          exp_cyc += 2;
          exp_err  = 1;
          exp_halt = 1;
          done = 1;
        end
      endcase
      if (!done) begin
        if (nxt != pc) exp_trace.push_back(nxt);
        pc = nxt;
      end
    end
  endtask

  // Driver: ready after drv_w valid cycles, done pulse drv_d cycles after the handshake.
  initial begin
    int done_cnt, vcnt;
    bit hs, rst_seen;
    done_cnt = 0;
    vcnt = 0;
    forever begin
      @(negedge clk);
      hs = cmd_valid && cmd_ready;
      rst_seen = reset;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        done_cnt = 0;
        vcnt = 0;
        cmd_done = 0;
        cmd_nack = 0;
        cmd_ready = 0;
      end else begin
        if (hs) done_cnt = drv_d;
        if (done_cnt > 0) begin
          done_cnt--;
          cmd_done = (done_cnt == 0);
          cmd_nack = cmd_done ? drv_nack : 1'b0;
        end else begin
          cmd_done = 0;
          cmd_nack = 0;
        end
        if (cmd_valid) begin
          cmd_ready = (vcnt >= drv_w);
          vcnt++;
        end else begin
          vcnt = 0;
          cmd_ready = 0;
        end
      end
    end
  end

  // Compare process: every cycle, offered command must match the model's next command.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (int'(rom_addr) != last_addr) begin
          obs_trace.push_back(int'(rom_addr));
          last_addr = int'(rom_addr);
        end
        if (cmd_valid === 1'b1) begin
          if (exp_cmds.size() == 0) check("unexpected cmd_valid", 32'(cmd_valid), 32'd0);
          else check("cmd op/data", 32'({cmd_op, cmd_data}), 32'(exp_cmds[0]));
          if (cmd_ready) begin
            obs_cmds.push_back({cmd_op, cmd_data});
            if (exp_cmds.size() > 0) void'(exp_cmds.pop_front());
          end
        end
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < RomDepth; i++) rom[i] = 16'h0000;
  endtask

  task automatic apply_reset();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    check("reset cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset cmd_op", 32'(cmd_op), 32'd0);
    check("reset cmd_data", 32'(cmd_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset rom_addr", 32'(rom_addr), 32'(StartAddr));
  endtask

  task automatic start_pulse();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic run_program(input int w, input int d, input bit nack, input int budget,
                             input bit expect_halt, input bit mid_start);
    drv_w = w;
    drv_d = d;
    drv_nack = nack;
    run_model(expect_halt ? 100000 : budget + 40);
    mon_en = 0;
    apply_reset();
    obs_cmds.delete();
    obs_trace.delete();
    obs_trace.push_back(StartAddr);
    last_addr = StartAddr;
    mon_en = 1;
    start_pulse();
    meas = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (mid_start) start = (n == 5);
      if (expect_halt && halted === 1'b1) begin
        meas = n;
        break;
      end
    end
    start = 0;
    if (expect_halt) begin
      if (meas == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL halt timeout: no halt within %0d cycles", budget);
      end
      check("run cycles", 32'(meas), 32'(exp_cyc));
      check("halted", 32'(halted), 32'(exp_halt));
      check("error", 32'(error), 32'(exp_err));
      check("busy after halt", 32'(busy), 32'd0);
      check("cmds outstanding", 32'(exp_cmds.size()), 32'd0);
      check("trace length", 32'(obs_trace.size()), 32'(exp_trace.size()));
      for (int i = 0; i < exp_trace.size() && i < obs_trace.size(); i++)
        check("trace addr", 32'(obs_trace[i]), 32'(exp_trace[i]));
    end else begin
      check("busy while looping", 32'(busy), 32'd1);
      check("halted while looping", 32'(halted), 32'd0);
      check("trace long enough", 32'(obs_trace.size() >= 8), 32'd1);
      for (int i = 0; i < 8 && i < obs_trace.size() && i < exp_trace.size(); i++)
        check("trace addr", 32'(obs_trace[i]), 32'(exp_trace[i]));
    end
    mon_en = 0;
  endtask

  initial begin
    reset = 1;
    start = 0;
    cmd_ready = 0;
    cmd_done = 0;
    cmd_nack = 0;

    // START, WRITE 0x40, STOP, HALT with immediate ready and done 3 cycles later
    clear_rom();
    rom[0] = 16'h1000; rom[1] = 16'h3040; rom[2] = 16'h2000; rom[3] = 16'h6000;
    run_program(0, 3, 0, 200, 1, 0);
    check("t1 cycles", 32'(meas), 32'd20);
    check("t1 cmd count", 32'(obs_cmds.size()), 32'd3);
    check("t1 cmd0", 32'(obs_cmds[0]), 32'h000);
    check("t1 cmd1", 32'(obs_cmds[1]), 32'h240);
    check("t1 cmd2", 32'(obs_cmds[2]), 32'h100);

    // WRITE 0xC0 with ready withheld for 10 cycles
    clear_rom();
    rom[0] = 16'h30C0; rom[1] = 16'h6000;
    run_program(10, 1, 0, 200, 1, 0);
    check("t2 cycles", 32'(meas), 32'd16);
    check("t2 cmd0", 32'(obs_cmds[0]), 32'h2C0);

    // DELAY 3, DELAY 0, HALT; a start pulse mid-delay must be ignored
    clear_rom();
    rom[0] = 16'h4003; rom[1] = 16'h4000; rom[2] = 16'h6000;
    run_program(0, 1, 0, 200, 1, 1);
    check("t3 cycles", 32'(meas), 32'd18);

    // JUMP 0x005 at address 2
    clear_rom();
    rom[2] = 16'h5005; rom[5] = 16'h6000;
    run_program(0, 1, 0, 200, 1, 0);
    check("t4 cycles", 32'(meas), 32'd8);
    check("t4 trace[3]", 32'(obs_trace[3]), 32'd5);

    // Jump to the top address, NOP there wraps PC to 0
    clear_rom();
    rom[0] = 16'h50FF;
    run_program(0, 1, 0, 40, 0, 0);
    check("t5 trace[1]", 32'(obs_trace[1]), 32'hFF);
    check("t5 trace[2]", 32'(obs_trace[2]), 32'h00);

    // Illegal opcode, then restart from HALTED
    clear_rom();
    rom[1] = 16'hF000;
    run_program(0, 1, 0, 200, 1, 0);
    check("t6 cycles", 32'(meas), 32'd4);
    check("t6 error", 32'(error), 32'd1);
    start_pulse();
    check("t6 restart error", 32'(error), 32'd0);
    check("t6 restart halted", 32'(halted), 32'd0);
    check("t6 restart busy", 32'(busy), 32'd1);
    check("t6 restart rom_addr", 32'(rom_addr), 32'(StartAddr));
    meas = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (halted === 1'b1) begin
        meas = n;
        break;
      end
    end
    check("t6 rerun cycles", 32'(meas), 32'd4);
    check("t6 rerun error", 32'(error), 32'd1);

    // NACKed WRITE
    clear_rom();
    rom[0] = 16'h3012; rom[1] = 16'h6000;
    run_program(0, 2, 1, 200, 1, 0);
`ifdef LED_TM1637_ACK_CHECK_EN
    check("t7 cycles", 32'(meas), 32'd5);
    check("t7 error", 32'(error), 32'd1);
    check("t7 rom_addr", 32'(rom_addr), 32'd0);
`else
    check("t7 cycles", 32'(meas), 32'd7);
    check("t7 error", 32'(error), 32'd0);
    check("t7 rom_addr", 32'(rom_addr), 32'd1);
`endif

    // Reset while a command is being offered
    clear_rom();
    rom[0] = 16'h3055; rom[1] = 16'h6000;
    drv_w = 50;
    drv_nack = 0;
    apply_reset();
    start_pulse();
    for (int n = 0; n < 20; n++) begin
      if (cmd_valid === 1'b1) break;
      @(posedge clk);
      #1;
    end
    check("t8 valid before reset", 32'(cmd_valid), 32'd1);
    check("t8 data before reset", 32'(cmd_data), 32'h55);
    apply_reset();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
